// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Time-shares one external combinational 32-bit ALU between two requesters
// (req0 = execute-stage issue, req1 = branch/address helper). A request is
// accepted only in IDLE. Its operands are registered onto the ALU ports.
// The ALU result is captured one cycle later (EXEC). The result is then held
// on the shared response bus (RESP) until the owning requester accepts it.
//
// Build option: define ALU_ARB_FIXED_PRIO_EN to make requester 0 win every
// tie. Without it, ties are broken round-robin starting with requester 0.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 6,
  parameter int FLAG_W = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [1:0]        i_req_valid,
  output logic [1:0]        o_req_ready,
  input  logic [DATA_W-1:0] i_req0_op1,
  input  logic [DATA_W-1:0] i_req0_op2,
  input  logic [CTRL_W-1:0] i_req0_ctrl,
  input  logic [FLAG_W-1:0] i_req0_flags,
  input  logic [DATA_W-1:0] i_req1_op1,
  input  logic [DATA_W-1:0] i_req1_op2,
  input  logic [CTRL_W-1:0] i_req1_ctrl,
  input  logic [FLAG_W-1:0] i_req1_flags,
  output logic [1:0]        o_resp_valid,
  input  logic [1:0]        i_resp_ready,
  output logic [DATA_W-1:0] o_resp_result,
  output logic              o_resp_overflow,
  output logic              o_resp_zero,
  output logic [DATA_W-1:0] o_alu_op1,
  output logic [DATA_W-1:0] o_alu_op2,
  output logic [CTRL_W-1:0] o_alu_control,
  output logic              o_alu_lw,
  output logic              o_alu_sw,
  output logic              o_alu_beq_bit,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic              i_alu_overflow,
  input  logic              i_alu_zero,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic                last_grant_q, last_grant_d;
`endif
  logic [DATA_W-1:0]   alu_op1_q, alu_op1_d;
  logic [DATA_W-1:0]   alu_op2_q, alu_op2_d;
  logic [CTRL_W-1:0]   alu_ctrl_q, alu_ctrl_d;
  logic [FLAG_W-1:0]   alu_flags_q, alu_flags_d;
  logic [DATA_W-1:0]   resp_result_q, resp_result_d;
  logic                resp_overflow_q, resp_overflow_d;
  logic                resp_zero_q, resp_zero_d;

  logic                winner;
  logic                accept;
  logic                resp_done;

  // Pick the requester to serve: a lone valid requester wins outright,
  // a tie goes to requester 0 (fixed priority) or to the one not served last.
  always_comb begin
    winner = 1'b0;
    case (i_req_valid)
      2'b10:   winner = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
      2'b11:   winner = 1'b0;
`else
      2'b11:   winner = ~last_grant_q;
`endif
      default: winner = 1'b0;
    endcase
  end

  // Handshakes: accept only from IDLE; only the owner's ready retires a response.
  always_comb begin
    accept    = (state_q == IDLE) && i_req_valid[winner];
    resp_done = (state_q == RESP) && i_resp_ready[owner_q];
  end

  // Per-requester ready/valid lines; each is one-hot because a single
  // winner/owner bit selects which line may rise.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign o_req_ready[gi]  = accept && (winner == 1'(gi));
    assign o_resp_valid[gi] = (state_q == RESP) && (owner_q == 1'(gi));
  end

  // Next-state and datapath loads: operands load on accept, results load in EXEC.
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    last_grant_d    = last_grant_q;
`endif
    alu_op1_d       = alu_op1_q;
    alu_op2_d       = alu_op2_q;
    alu_ctrl_d      = alu_ctrl_q;
    alu_flags_d     = alu_flags_q;
    resp_result_d   = resp_result_q;
    resp_overflow_d = resp_overflow_q;
    resp_zero_d     = resp_zero_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = EXEC;
          owner_d      = winner;
`ifndef ALU_ARB_FIXED_PRIO_EN
          last_grant_d = winner;
`endif
          if (winner) begin
            alu_op1_d   = i_req1_op1;
            alu_op2_d   = i_req1_op2;
            alu_ctrl_d  = i_req1_ctrl;
            alu_flags_d = i_req1_flags;
          end else begin
            alu_op1_d   = i_req0_op1;
            alu_op2_d   = i_req0_op2;
            alu_ctrl_d  = i_req0_ctrl;
            alu_flags_d = i_req0_flags;
          end
        end
      end
      EXEC: begin
        // The ALU has had a full cycle to settle on the registered operands.
        state_d         = RESP;
        resp_result_d   = i_alu_result;
        resp_overflow_d = i_alu_overflow;
        resp_zero_d     = i_alu_zero;
      end
      RESP: begin
        // Returning to IDLE first keeps a new accept out of the retire cycle.
        if (resp_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight operation.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q         <= IDLE;
      owner_q         <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant_q    <= 1'b1;
`endif
      alu_op1_q       <= '0;
      alu_op2_q       <= '0;
      alu_ctrl_q      <= '0;
      alu_flags_q     <= '0;
      resp_result_q   <= '0;
      resp_overflow_q <= 1'b0;
      resp_zero_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant_q    <= last_grant_d;
`endif
      alu_op1_q       <= alu_op1_d;
      alu_op2_q       <= alu_op2_d;
      alu_ctrl_q      <= alu_ctrl_d;
      alu_flags_q     <= alu_flags_d;
      resp_result_q   <= resp_result_d;
      resp_overflow_q <= resp_overflow_d;
      resp_zero_q     <= resp_zero_d;
    end
  end

  assign o_alu_op1       = alu_op1_q;
  assign o_alu_op2       = alu_op2_q;
  assign o_alu_control   = alu_ctrl_q;
  assign o_alu_lw        = alu_flags_q[2];
  assign o_alu_sw        = alu_flags_q[1];
  assign o_alu_beq_bit   = alu_flags_q[0];
  assign o_resp_result   = resp_result_q;
  assign o_resp_overflow = resp_overflow_q;
  assign o_resp_zero     = resp_zero_q;
  assign o_busy          = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter. It provides a behavioural ALU on the
// o_alu_* / i_alu_* ports. Each requester has a queue of pending operations
// and a scoreboard queue of expected responses. A monitor follows the
// arbiter's protocol at transaction level and compares on every cycle.
`timescale 1ns/1ps
module tb_alu_share_arbiter;
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  i_req_valid, o_req_ready, o_resp_valid, i_resp_ready;
  logic [31:0] i_req0_op1, i_req0_op2, i_req1_op1, i_req1_op2;
  logic [5:0]  i_req0_ctrl, i_req1_ctrl;
  logic [2:0]  i_req0_flags, i_req1_flags;
  logic [31:0] o_resp_result, o_alu_op1, o_alu_op2, alu_res;
  logic        o_resp_overflow, o_resp_zero, alu_ovf, alu_zero;
  logic [5:0]  o_alu_control;
  logic        o_alu_lw, o_alu_sw, o_alu_beq_bit, o_busy;

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req0_op1(i_req0_op1), .i_req0_op2(i_req0_op2),
    .i_req0_ctrl(i_req0_ctrl), .i_req0_flags(i_req0_flags),
    .i_req1_op1(i_req1_op1), .i_req1_op2(i_req1_op2),
    .i_req1_ctrl(i_req1_ctrl), .i_req1_flags(i_req1_flags),
    .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
    .o_resp_result(o_resp_result), .o_resp_overflow(o_resp_overflow),
    .o_resp_zero(o_resp_zero),
    .o_alu_op1(o_alu_op1), .o_alu_op2(o_alu_op2), .o_alu_control(o_alu_control),
    .o_alu_lw(o_alu_lw), .o_alu_sw(o_alu_sw), .o_alu_beq_bit(o_alu_beq_bit),
    .i_alu_result(alu_res), .i_alu_overflow(alu_ovf), .i_alu_zero(alu_zero),
    .o_busy(o_busy)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  ctrl;
    logic [2:0]  flags;
    logic [31:0] res;
    logic        ovf;
    logic        zero;
  } txn_t;

  txn_t todo_q[2][$];   // operations a requester still has to get accepted
  txn_t exp_q[2][$];    // expected responses, in per-requester order

  int n_checks = 0;
  int n_fail   = 0;
  int drop_pct = 0;            // chance a pending requester idles its valid
  logic       rr_force_en = 1'b1;
  logic [1:0] rr_force    = 2'b11;

  // Signed arithmetic with overflow taken from the exact 64-bit sum.
  function automatic logic [32:0] alu_ref(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
    longint s;
    logic [31:0] r;
    logic v;
    s = 0; r = '0; v = 1'b0;
    case (c)
      OP_ADD: s = longint'($signed(a)) + longint'($signed(b));
      OP_SUB: s = longint'($signed(a)) - longint'($signed(b));
      default: s = 0;
    endcase
    if (c == OP_ADD || c == OP_SUB) begin
      r = s[31:0];
      v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end else if (c == OP_AND) r = a & b;
    else if (c == OP_OR) r = a | b;
    return {v, r};
  endfunction

  assign {alu_ovf, alu_res} = alu_ref(o_alu_control, o_alu_op1, o_alu_op2);
  assign alu_zero = (alu_res == 32'd0);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_req(input int n, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] c, input logic [2:0] f,
                         input logic [31:0] r, input logic v, input logic z);
    txn_t t;
    t.a = a; t.b = b; t.ctrl = c; t.flags = f; t.res = r; t.ovf = v; t.zero = z;
    todo_q[n].push_back(t);
    exp_q[n].push_back(t);
    $display("issue req%0d ctrl=%b a=%h b=%h flags=%b -> exp res=%h ovf=%0b zero=%0b",
             n, c, a, b, f, r, v, z);
  endtask

  task automatic rand_req(input int n);
    logic [31:0] a, b;
    logic [5:0]  c;
    logic [32:0] rv;
    logic [5:0]  ops [4];
    ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_AND; ops[3] = OP_OR;
    a = $urandom;
    b = ($urandom_range(3) == 0) ? a : $urandom;
    c = ops[$urandom_range(3)];
    rv = alu_ref(c, a, b);
    add_req(n, a, b, c, 3'($urandom_range(7)), rv[31:0], rv[32], rv[31:0] == 32'd0);
  endtask

  task automatic present(input int n);
    txn_t t;
    logic v;
    if (todo_q[n].size() != 0 && $urandom_range(99) >= drop_pct) begin
      t = todo_q[n][0];
      v = 1'b1;
    end else begin
      t.a = $urandom; t.b = $urandom; t.ctrl = 6'($urandom); t.flags = 3'($urandom);
      v = 1'b0;
    end
    if (n == 0) begin
      i_req_valid[0] = v; i_req0_op1 = t.a; i_req0_op2 = t.b; i_req0_ctrl = t.ctrl; i_req0_flags = t.flags;
    end else begin
      i_req_valid[1] = v; i_req1_op1 = t.a; i_req1_op2 = t.b; i_req1_ctrl = t.ctrl; i_req1_flags = t.flags;
    end
  endtask

  // Driver: retire accepted operations, then present the next ones after the edge.
  initial begin : driver
    logic [1:0] acc;
    i_req_valid = 2'b00; i_resp_ready = 2'b00;
    i_req0_op1 = '0; i_req0_op2 = '0; i_req0_ctrl = '0; i_req0_flags = '0;
    i_req1_op1 = '0; i_req1_op2 = '0; i_req1_ctrl = '0; i_req1_flags = '0;
    forever begin
      @(negedge clk);
      acc = rst ? 2'b00 : (o_req_ready & i_req_valid);
      @(posedge clk);
      #1;
      for (int n = 0; n < 2; n++) begin
        if (acc[n] && todo_q[n].size() != 0) void'(todo_q[n].pop_front());
        present(n);
      end
      i_resp_ready = rr_force_en ? rr_force
                                 : {1'($urandom_range(99) < 60), 1'($urandom_range(99) < 60)};
    end
  end

  // Winner rule: a lone requester wins; ties go to req0 (fixed) or alternate.
  function automatic int pick(input logic [1:0] v, input int last);
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
`ifdef ALU_ARB_FIXED_PRIO_EN
    return 0;
`else
    return 1 - last;
`endif
  endfunction

  // Monitor: transaction-level model (phase 0 idle, 1 exec, 2 respond).
  initial begin : monitor
    int   phase_m, owner_m, last_m, w;
    logic [1:0] exp_rdy;
    txn_t cap, e;
    phase_m = 0; owner_m = 0; last_m = 1; w = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        phase_m = 0; last_m = 1;
      end else begin
        exp_rdy = 2'b00;
        w = 0;
        if (phase_m == 0 && i_req_valid != 2'b00) begin
          w = pick(i_req_valid, last_m);
          exp_rdy = 2'b01 << w;
        end
        chk("req_ready", 64'(o_req_ready), 64'(exp_rdy));
        chk("busy", 64'(o_busy), 64'(phase_m != 0));
        chk("resp_valid", 64'(o_resp_valid), (phase_m == 2) ? 64'(2'b01 << owner_m) : 64'd0);
        if (phase_m == 1) begin
          chk("alu_op1", 64'(o_alu_op1), 64'(cap.a));
          chk("alu_op2", 64'(o_alu_op2), 64'(cap.b));
          chk("alu_ctrl", 64'(o_alu_control), 64'(cap.ctrl));
          chk("alu_flags", 64'({o_alu_lw, o_alu_sw, o_alu_beq_bit}), 64'(cap.flags));
        end
        if (phase_m == 2) begin
          if (exp_q[owner_m].size() == 0) begin
            chk("resp_unexpected", 64'd1, 64'd0);
          end else begin
            e = exp_q[owner_m][0];
            chk("resp_result", 64'(o_resp_result), 64'(e.res));
            chk("resp_overflow", 64'(o_resp_overflow), 64'(e.ovf));
            chk("resp_zero", 64'(o_resp_zero), 64'(e.zero));
          end
        end
        case (phase_m)
          0: if (exp_rdy != 2'b00) begin
               owner_m = w; last_m = w; phase_m = 1;
               if (w == 0) begin
                 cap.a = i_req0_op1; cap.b = i_req0_op2; cap.ctrl = i_req0_ctrl; cap.flags = i_req0_flags;
               end else begin
                 cap.a = i_req1_op1; cap.b = i_req1_op2; cap.ctrl = i_req1_ctrl; cap.flags = i_req1_flags;
               end
               $display("accept req%0d at t=%0t", w, $time);
             end
          1: phase_m = 2;
          default: if (i_resp_ready[owner_m]) begin
               if (exp_q[owner_m].size() != 0) void'(exp_q[owner_m].pop_front());
               $display("response req%0d res=%h ovf=%0b zero=%0b", owner_m,
                        o_resp_result, o_resp_overflow, o_resp_zero);
               phase_m = 0;
             end
        endcase
      end
    end
  end

  task automatic clear_queues();
    for (int n = 0; n < 2; n++) begin
      todo_q[n].delete();
      exp_q[n].delete();
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #3; rst = 1'b1;
    @(negedge clk); clear_queues();
    @(posedge clk); #3; rst = 1'b0;
  endtask

  task automatic wait_drain(input int max);
    int k = 0;
    while ((todo_q[0].size() + todo_q[1].size() + exp_q[0].size() + exp_q[1].size()) != 0 && k < max) begin
      @(negedge clk); k++;
    end
    if (k >= max) chk("drain_timeout", 64'd1, 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_until_busy(input logic want_resp, input int max);
    int k = 0;
    @(negedge clk);
    while (!(want_resp ? (o_resp_valid != 2'b00) : o_busy) && k < max) begin
      @(negedge clk); k++;
    end
    if (k >= max) chk("wait_timeout", 64'd1, 64'd0);
  endtask

  initial begin : main
    logic [32:0] rv;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_req_ready", 64'(o_req_ready), 64'd0);
    chk("rst_resp_valid", 64'(o_resp_valid), 64'd0);
    chk("rst_alu_op1", 64'(o_alu_op1), 64'd0);
    chk("rst_alu_ctrl", 64'(o_alu_control), 64'd0);
    chk("rst_resp_result", 64'(o_resp_result), 64'd0);
    @(posedge clk); #3; rst = 1'b0;

    // Single ADD on req0.
    add_req(0, 32'd5, 32'd3, OP_ADD, 3'b000, 32'd8, 1'b0, 1'b0);
    wait_drain(50);

    // Simultaneous requests straight after reset: req0 first.
    do_reset();
    add_req(0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, OP_AND, 3'b000, 32'h00F0_00F0, 1'b0, 1'b0);
    add_req(1, 32'd7, 32'd7, OP_SUB, 3'b000, 32'd0, 1'b0, 1'b1);
    wait_drain(50);

    // Six operations with both requesters continuously valid.
    for (int i = 0; i < 3; i++) begin
      rand_req(0);
      rand_req(1);
    end
    wait_drain(100);

    // Signed overflow on req1 with flags 101.
    add_req(1, 32'h7FFF_FFFF, 32'd1, OP_ADD, 3'b101, 32'h8000_0000, 1'b1, 1'b0);
    wait_drain(50);

    // Backpressure on req0 while req1 waits; req1's ready is ignored.
    rr_force = 2'b10;
    rv = alu_ref(OP_OR, 32'h1234_0000, 32'h0000_5678);
    add_req(0, 32'h1234_0000, 32'h0000_5678, OP_OR, 3'b010, rv[31:0], 1'b0, 1'b0);
    add_req(1, 32'd100, 32'd1, OP_SUB, 3'b001, 32'd99, 1'b0, 1'b0);
    wait_until_busy(1'b1, 20);
    repeat (5) @(negedge clk);
    rr_force = 2'b11;
    wait_drain(50);

    // Reset while in EXEC: outputs drop without waiting for a clock edge.
    add_req(0, 32'd1, 32'd2, OP_ADD, 3'b000, 32'd3, 1'b0, 1'b0);
    wait_until_busy(1'b0, 20);
    #2; rst = 1'b1; #1;
    chk("rst_exec_resp_valid", 64'(o_resp_valid), 64'd0);
    chk("rst_exec_busy", 64'(o_busy), 64'd0);
    @(negedge clk); clear_queues();
    @(posedge clk); #3; rst = 1'b0;

    // Reset while holding a response.
    rr_force = 2'b00;
    add_req(1, 32'd9, 32'd4, OP_SUB, 3'b000, 32'd5, 1'b0, 1'b0);
    wait_until_busy(1'b1, 20);
    chk("resp_before_rst", 64'(o_resp_valid), 64'd2);
    #2; rst = 1'b1; #1;
    chk("rst_resp_resp_valid", 64'(o_resp_valid), 64'd0);
    chk("rst_resp_busy", 64'(o_busy), 64'd0);
    @(negedge clk); clear_queues();
    @(posedge clk); #3; rst = 1'b0;
    rr_force = 2'b11;

    // After reset both valid: req0 granted first.
    add_req(0, 32'd10, 32'd20, OP_ADD, 3'b100, 32'd30, 1'b0, 1'b0);
    add_req(1, 32'hFFFF_FFFF, 32'h8000_0000, OP_AND, 3'b011, 32'h8000_0000, 1'b0, 1'b0);
    wait_drain(50);

    // Random traffic: dropped valids, random response backpressure.
    drop_pct = 25;
    rr_force_en = 1'b0;
    for (int i = 0; i < 40; i++) begin
      for (int n = 0; n < 2; n++)
        if (todo_q[n].size() < 2 && $urandom_range(1) == 1) rand_req(n);
      repeat ($urandom_range(4)) @(negedge clk);
    end
    drop_pct = 0;
    wait_drain(600);
    rr_force_en = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
